// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard scheduler: scoreboards in-flight ALU/load/mul writes,
// raises stall_decode and picks RF / ALU-bypass / MEM-bypass per source.
module decode_hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int MUL_LAT  = 5
) (
  input  logic                clock,
  input  logic                reset_c,
  input  logic                flush,
  input  logic                dec_valid,
  input  logic [ADDR_W-1:0]   dec_ra,
  input  logic [ADDR_W-1:0]   dec_rb,
  input  logic                dec_rb_used,
  input  logic [ADDR_W-1:0]   dec_rd,
  input  logic                dec_rd_wr,
  input  logic [1:0]          dec_class,
  input  logic                ld_ret_valid,
  input  logic [ADDR_W-1:0]   ld_ret_rd,
  output logic                stall_decode,
  output logic                dec_issue,
  output logic [1:0]          bp_sel_a,
  output logic [1:0]          bp_sel_b,
  output logic [NUM_REGS-1:0] ld_pending
);

  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_MUL  = 2'd2;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  // ALU shadow pipe: stage 1 = issued last cycle, stage 2 = two cycles ago
  logic              alu_v1;
  logic [ADDR_W-1:0] alu_rd1;
  logic              alu_v2;
  logic [ADDR_W-1:0] alu_rd2;

  logic              mul_busy;
  logic [ADDR_W-1:0] mul_rd;
  logic [3:0]        mul_cnt;

  logic [1:0]          sel_a;
  logic [1:0]          sel_b;
  logic                hz_a;
  logic                hz_b;
  logic                hz_waw;
  logic                hz_struct;
  logic                stall_raw;
  logic                issue_raw;
  logic [NUM_REGS-1:0] ld_set;
  logic [NUM_REGS-1:0] ld_clr;
  logic [NUM_REGS-1:0] ld_next;

  function automatic logic ret_hit(input logic              rv,
                                   input logic [ADDR_W-1:0] rrd,
                                   input logic [ADDR_W-1:0] s);
    return rv && (rrd == s);
  endfunction

  // Youngest in-flight producer wins; r0 always reads the register file.
  function automatic logic [1:0] src_sel(input logic [ADDR_W-1:0] s,
                                         input logic              v1,
                                         input logic [ADDR_W-1:0] rd1,
                                         input logic              v2,
                                         input logic [ADDR_W-1:0] rd2,
                                         input logic              rv,
                                         input logic [ADDR_W-1:0] rrd);
    if (s == '0)
      return SEL_RF;
    else if (v1 && (rd1 == s))
      return SEL_ALU;
    else if (v2 && (rd2 == s))
      return SEL_MEM;
    else if (ret_hit(rv, rrd, s))
      return SEL_MEM;
    else
      return SEL_RF;
  endfunction

  // A register is blocked while a load to it is outstanding (unless it is
  // returning right now) or while the multiplier still owns it.
  function automatic logic reg_blocked(input logic [ADDR_W-1:0]   s,
                                       input logic [NUM_REGS-1:0] ldp,
                                       input logic                rv,
                                       input logic [ADDR_W-1:0]   rrd,
                                       input logic                mb,
                                       input logic [ADDR_W-1:0]   mrd);
    logic ld_blk;
    logic mul_blk;
    ld_blk  = ldp[s] && !ret_hit(rv, rrd, s);
    mul_blk = mb && (mrd == s);
    return (s != '0) && (ld_blk || mul_blk);
  endfunction

  always_comb begin
    sel_a = src_sel(dec_ra, alu_v1, alu_rd1, alu_v2, alu_rd2,
                    ld_ret_valid, ld_ret_rd);
    sel_b = SEL_RF;
    if (dec_rb_used)
      sel_b = src_sel(dec_rb, alu_v1, alu_rd1, alu_v2, alu_rd2,
                      ld_ret_valid, ld_ret_rd);

    hz_a = reg_blocked(dec_ra, ld_pending, ld_ret_valid, ld_ret_rd,
                       mul_busy, mul_rd);
    hz_b = dec_rb_used &&
           reg_blocked(dec_rb, ld_pending, ld_ret_valid, ld_ret_rd,
                       mul_busy, mul_rd);
    hz_waw = dec_rd_wr &&
             reg_blocked(dec_rd, ld_pending, ld_ret_valid, ld_ret_rd,
                         mul_busy, mul_rd);
    hz_struct = (dec_class == CLS_MUL) && mul_busy;

    stall_raw = dec_valid && (hz_a || hz_b || hz_waw || hz_struct);
    issue_raw = dec_valid && !stall_raw && !flush;
  end

  // Outputs read as idle for the whole time reset is held.
  always_comb begin
    stall_decode = 1'b0;
    dec_issue    = 1'b0;
    bp_sel_a     = SEL_RF;
    bp_sel_b     = SEL_RF;
    if (!reset_c) begin
      stall_decode = stall_raw;
      dec_issue    = issue_raw;
      bp_sel_a     = sel_a;
      bp_sel_b     = sel_b;
    end
  end

  // A new load to rd is younger than a return to the same rd, so set wins.
  always_comb begin
    ld_set = '0;
    ld_clr = '0;
    if (issue_raw && (dec_class == CLS_LOAD) && (dec_rd != '0))
      ld_set[dec_rd] = 1'b1;
    if (ld_ret_valid)
      ld_clr[ld_ret_rd] = 1'b1;
    ld_next = (ld_pending & ~ld_clr) | ld_set;
  end

  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      alu_v1     <= 1'b0;
      alu_rd1    <= '0;
      alu_v2     <= 1'b0;
      alu_rd2    <= '0;
      mul_busy   <= 1'b0;
      mul_rd     <= '0;
      mul_cnt    <= '0;
      ld_pending <= '0;
    end else begin
      alu_v1  <= issue_raw && (dec_class == CLS_ALU) && dec_rd_wr;
      alu_rd1 <= dec_rd;
      alu_v2  <= alu_v1 && !flush;
      alu_rd2 <= alu_rd1;

      ld_pending <= ld_next;

      if (flush) begin
        mul_busy <= 1'b0;
        mul_rd   <= '0;
        mul_cnt  <= '0;
      end else if (issue_raw && (dec_class == CLS_MUL) && (dec_rd != '0)) begin
        mul_busy <= 1'b1;
        mul_rd   <= dec_rd;
        mul_cnt  <= MUL_CNT_INIT;
      end else if (mul_busy) begin
        if (mul_cnt == '0)
          mul_busy <= 1'b0;
        else
          mul_cnt <= mul_cnt - 4'd1;
      end
    end
  end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
Hazard scheduler for the decode stage. It tracks in-flight register writes from ALU, load and multi-cycle multiply instructions in a scoreboard. It drives the decode stage's stall_decode and selects, per source operand, between the register file, the ALU bypass and the MEM bypass. It sits between the fetch/decode boundary and the ALU/MEM writeback paths.

Parameters:
NUM_REGS, 32, architectural registers; register 0 is never a hazard.
ADDR_W, 5, register address width.
MUL_LAT, 5, cycles from mul issue until its result is written into the RF (2..15).

Ports:
clock  in  1  system clock.
reset_c  in  1  asynchronous, active-high reset.
flush  in  1  pipeline flush (exception/branch); one-cycle pulse.
dec_valid  in  1  decode holds a valid instruction this cycle.
dec_ra  in  ADDR_W  source A address.
dec_rb  in  ADDR_W  source B address (for stores, the rd-as-source address).
dec_rb_used  in  1  source B is a register read.
dec_rd  in  ADDR_W  destination address.
dec_rd_wr  in  1  instruction writes rd.
dec_class  in  2  0=ALU, 1=LOAD, 2=MUL, 3=other (store/branch, no latency class).
ld_ret_valid  in  1  load data returning on the MEM bypass this cycle.
ld_ret_rd  in  ADDR_W  destination of the returning load.
stall_decode  out  1  hold fetch/decode this cycle.
dec_issue  out  1  instruction accepted (dec_valid && !stall_decode).
bp_sel_a  out  2  source A select: 0=RF, 1=ALU bypass, 2=MEM bypass.
bp_sel_b  out  2  source B select, same encoding.
ld_pending  out  NUM_REGS  scoreboard of outstanding loads (debug/verif).

Behaviour:
- State:
  - ld_pending[NUM_REGS] bit vector.
  - ALU shadow pipe: alu_v1/alu_rd1 (issued 1 cycle ago) and alu_v2/alu_rd2 (2 cycles ago).
  - mul_busy, mul_rd, 4-bit mul_cnt.
- Reset (async): all of the above cleared; stall_decode=0, dec_issue=0, bp_sel_a/b=0, ld_pending=0.
- Operand hazard, per used source s (A always used; B only if dec_rb_used); s==0 is never a hazard and selects RF:
  - Bypass priority, most recent first:
    - alu_v1 && alu_rd1==s → ALU (1).
    - else alu_v2 && alu_rd2==s → MEM (2).
    - else ld_ret_valid && ld_ret_rd==s → MEM (2), no stall.
    - else RF (0).
  - Stall if ld_pending[s] and not returning this cycle.
  - Stall if mul_busy && mul_rd==s.
- WAW: stall if dec_rd_wr && dec_rd!=0 && (ld_pending[dec_rd] without same-cycle return, or mul_busy && mul_rd==dec_rd).
- Structural: stall if dec_class==MUL && mul_busy.
- stall_decode = dec_valid && any hazard above; purely combinational from state and inputs; 0 when !dec_valid.
- On dec_issue (registered, next edge):
  - ALU with rd_wr → alu_v1=1, alu_rd1=dec_rd; otherwise alu_v1=0.
  - alu_v2 <= alu_v1 and alu_rd2 <= alu_rd1 every cycle.
  - LOAD with rd!=0 → set ld_pending[dec_rd].
  - MUL with rd!=0 → mul_busy=1, mul_rd=dec_rd, mul_cnt=MUL_LAT-1.
- mul_cnt decrements each cycle while busy; mul_busy clears on the edge where mul_cnt==0. Sources matching mul_rd stall through that cycle and read RF the next cycle.
- ld_ret_valid clears ld_pending[ld_ret_rd] at the edge.
- Same-cycle set and clear of the same bit: the set wins, because the new load is younger.
- A return for a non-pending register is ignored.
- Stall cycles never allocate state. The ALU pipe still shifts (alu_v1 <= 0).
- flush:
  - Clears alu_v1/alu_v2 and mul state.
  - ld_pending is kept, because outstanding loads still return.
  - Forces dec_issue=0 that cycle.

Test Plan:
1. ALU r3 issued at cycle t, consumer of r3 at t+1 → bp_sel_a=1, no stall. Consumer at t+2 → bp_sel_a=2. Consumer at t+3 → 0.
2. LOAD r5, then consumer of r5 with return at t+4 → stall_decode=1 for cycles t+1..t+3. At t+4 bp_sel=2, stall=0, ld_pending[5]=0 after the edge.
3. MUL r7 (MUL_LAT=5), then consumer of r7 → 5 stall cycles, then RF read. A second MUL issued right after the first stalls until mul_busy drops.
4. Instruction with ra=rb=0 while r0 is written by load/ALU → no stall, bp_sel=0.
5. LOAD r9 issued in the same cycle as the return for an older r9 load → ld_pending[9]=1 afterwards. A later consumer keeps stalling until the second return.
6. Reset asserted mid-MUL with ld_pending=0x20 → all outputs and state 0 immediately. Flush mid-MUL → mul_busy=0, ld_pending unchanged.
